// File: rtl/cpu_mem_arb_if.sv
// Bus bundle between the CPU fetch/load-store ports, the arbiter and the memory.
// Signal directions in the names are as seen from the arbiter.
interface cpu_mem_arb_if #(
    parameter int WIDTH = 16
);
    logic             i_if_read;
    logic [WIDTH-1:0] i_if_addr;
    logic             o_if_waitreq;
    logic             o_if_valid;
    logic [WIDTH-1:0] o_if_rddata;

    logic             i_ls_read;
    logic             i_ls_write;
    logic [WIDTH-1:0] i_ls_addr;
    logic [WIDTH-1:0] i_ls_wrdata;
    logic             o_ls_waitreq;
    logic             o_ls_valid;
    logic [WIDTH-1:0] o_ls_rddata;

    logic [WIDTH-1:0] o_mem_addr;
    logic             o_mem_read;
    logic             o_mem_write;
    logic [WIDTH-1:0] o_mem_wrdata;
    logic             i_mem_waitreq;
    logic [WIDTH-1:0] i_mem_rddata;

    modport slave (
        input  i_if_read, i_if_addr,
        output o_if_waitreq, o_if_valid, o_if_rddata,
        input  i_ls_read, i_ls_write, i_ls_addr, i_ls_wrdata,
        output o_ls_waitreq, o_ls_valid, o_ls_rddata,
        output o_mem_addr, o_mem_read, o_mem_write, o_mem_wrdata,
        input  i_mem_waitreq, i_mem_rddata
    );

    modport master (
        output i_if_read, i_if_addr,
        input  o_if_waitreq, o_if_valid, o_if_rddata,
        output i_ls_read, i_ls_write, i_ls_addr, i_ls_wrdata,
        input  o_ls_waitreq, o_ls_valid, o_ls_rddata,
        input  o_mem_addr, o_mem_read, o_mem_write, o_mem_wrdata,
        output i_mem_waitreq, i_mem_rddata
    );
endinterface

// File: rtl/cpu_mem_arb.sv
// Fetch vs load/store arbiter onto one fixed-latency memory port, with a read
// owner tag pipeline and a starvation guard that temporarily favours fetch.
module cpu_mem_arb #(
    parameter int WIDTH      = 16,
    parameter int RDLAT      = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          i_clk,
    input  logic          i_reset,
    cpu_mem_arb_if.slave  bus
);
    logic             w_if_req;
    logic             w_ls_req;
    logic             w_ls_wr;
    logic             w_gnt_if;
    logic             w_gnt_ls;
    logic             w_acc_if;
    logic             w_acc_ls;
    logic             w_acc_rd;
    logic [WIDTH-1:0] w_mem_addr;
    logic [WIDTH-1:0] w_mem_wrdata;
    logic [3:0]       w_starve_nxt;

    logic [3:0]       r_starve;
    logic             r_prio_if;
    logic [RDLAT-1:0] r_vld_pipe;
    logic [RDLAT-1:0] r_own_pipe;   // 1 = load/store owns the read

    always_comb begin
        w_if_req = bus.i_if_read & ~i_reset;
        w_ls_req = (bus.i_ls_read | bus.i_ls_write) & ~i_reset;
        w_ls_wr  = bus.i_ls_write;
        w_gnt_ls = w_ls_req & ~(r_prio_if & w_if_req);
        w_gnt_if = w_if_req & ~w_gnt_ls;
        w_acc_if = w_gnt_if & ~bus.i_mem_waitreq;
        w_acc_ls = w_gnt_ls & ~bus.i_mem_waitreq;
        w_acc_rd = w_acc_if | (w_acc_ls & ~w_ls_wr);

        w_mem_addr   = '0;
        w_mem_wrdata = '0;
        if (w_gnt_ls) begin
            w_mem_addr   = bus.i_ls_addr;
            w_mem_wrdata = bus.i_ls_wrdata;
        end else if (w_gnt_if) begin
            w_mem_addr   = bus.i_if_addr;
        end

        // A stalled memory leaves the counter alone unless fetch has gone away.
        w_starve_nxt = r_starve;
        if (w_acc_if || !w_if_req)
            w_starve_nxt = 4'd0;
        else if (w_acc_ls && r_starve != 4'hF)
            w_starve_nxt = r_starve + 4'd1;
    end

    assign bus.o_mem_addr   = w_mem_addr;
    assign bus.o_mem_wrdata = w_mem_wrdata;
    assign bus.o_mem_read   = w_gnt_if | (w_gnt_ls & ~w_ls_wr);
    assign bus.o_mem_write  = w_gnt_ls & w_ls_wr;

    assign bus.o_if_waitreq = i_reset | (w_if_req & (~w_gnt_if | bus.i_mem_waitreq));
    assign bus.o_ls_waitreq = i_reset | (w_ls_req & (~w_gnt_ls | bus.i_mem_waitreq));

    assign bus.o_if_valid  = r_vld_pipe[RDLAT-1] & ~r_own_pipe[RDLAT-1];
    assign bus.o_ls_valid  = r_vld_pipe[RDLAT-1] &  r_own_pipe[RDLAT-1];
    assign bus.o_if_rddata = bus.i_mem_rddata;
    assign bus.o_ls_rddata = bus.i_mem_rddata;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_starve   <= 4'd0;
            r_prio_if  <= 1'b0;
            r_vld_pipe <= '0;
            r_own_pipe <= '0;
        end else begin
            for (int k = RDLAT - 1; k > 0; k--) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_own_pipe[k] <= r_own_pipe[k-1];
            end
            r_vld_pipe[0] <= w_acc_rd;
            r_own_pipe[0] <= w_acc_ls;

            r_starve <= w_starve_nxt;
            // Priority flips the cycle after the counter hits its limit.
            if (w_acc_if)
                r_prio_if <= 1'b0;
            else if (w_starve_nxt >= 4'(STARVE_MAX))
                r_prio_if <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_mem_arb.sv
// Directed bench: RDLAT=1 instance for arbitration/starvation/store/stall,
// RDLAT=3 instance for reset with reads in flight.
module tb_cpu_mem_arb;
    logic clk = 1'b0;
    logic rst1, rst2;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cpu_mem_arb_if #(.WIDTH(16)) b1 ();
    cpu_mem_arb_if #(.WIDTH(16)) b2 ();

    cpu_mem_arb #(.WIDTH(16), .RDLAT(1), .STARVE_MAX(3)) dut1 (
        .i_clk(clk), .i_reset(rst1), .bus(b1.slave));
    cpu_mem_arb #(.WIDTH(16), .RDLAT(3), .STARVE_MAX(3)) dut2 (
        .i_clk(clk), .i_reset(rst2), .bus(b2.slave));

    // Memory for dut1: unwritten words read as addr ^ 0xA5A5, latency 1.
    logic [15:0] wmem  [0:1023];
    logic        wflag [0:1023];
    logic [15:0] rd1;
    always @(posedge clk) begin
        if (rst1) begin
            for (int i = 0; i < 1024; i++) wflag[i] <= 1'b0;
        end else begin
            if (b1.o_mem_write && !b1.i_mem_waitreq) begin
                wmem[b1.o_mem_addr[9:0]]  <= b1.o_mem_wrdata;
                wflag[b1.o_mem_addr[9:0]] <= 1'b1;
            end
            if (b1.o_mem_read && !b1.i_mem_waitreq)
                rd1 <= wflag[b1.o_mem_addr[9:0]] ? wmem[b1.o_mem_addr[9:0]]
                                                 : (b1.o_mem_addr ^ 16'hA5A5);
        end
    end
    assign b1.i_mem_rddata = rd1;

    // Memory for dut2: read-only, latency 3.
    logic [15:0] p2 [0:2];
    always @(posedge clk) begin
        p2[0] <= b2.o_mem_read ? (b2.o_mem_addr ^ 16'hA5A5) : 16'hDEAD;
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign b2.i_mem_rddata = p2[2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        b1.i_if_read = 1'b1; b1.i_if_addr = 16'h0000;
        b1.i_ls_read = 1'b1; b1.i_ls_write = 1'b0; b1.i_ls_addr = 16'h0000;
        b1.i_ls_wrdata = 16'h0000; b1.i_mem_waitreq = 1'b0;
        b2.i_if_read = 1'b0; b2.i_if_addr = 16'h0000;
        b2.i_ls_read = 1'b0; b2.i_ls_write = 1'b0; b2.i_ls_addr = 16'h0000;
        b2.i_ls_wrdata = 16'h0000; b2.i_mem_waitreq = 1'b0;
        #2;
        chk("rst_if_wait", b1.o_if_waitreq, 1);
        chk("rst_ls_wait", b1.o_ls_waitreq, 1);
        chk("rst_mem_rd",  b1.o_mem_read, 0);
        chk("rst_mem_wr",  b1.o_mem_write, 0);
        chk("rst_if_vld",  b1.o_if_valid, 0);
        chk("rst_ls_vld",  b1.o_ls_valid, 0);
        tick(); tick();
        rst1 = 1'b0; rst2 = 1'b0;
        b1.i_if_read = 1'b0; b1.i_ls_read = 1'b0;
        tick();

        // Fetch-only burst
        b1.i_if_read = 1'b1; b1.i_if_addr = 16'h0000; #1;
        chk("t1_wait0", b1.o_if_waitreq, 0);
        chk("t1_mrd0",  b1.o_mem_read, 1);
        tick();
        b1.i_if_addr = 16'h0002; #1;
        chk("t1_wait1", b1.o_if_waitreq, 0);
        chk("t1_vld0",  b1.o_if_valid, 1);
        chk("t1_dat0",  b1.o_if_rddata, 16'hA5A5);
        tick();
        b1.i_if_addr = 16'h0004; #1;
        chk("t1_vld1",  b1.o_if_valid, 1);
        chk("t1_dat1",  b1.o_if_rddata, 16'hA5A7);
        tick();
        b1.i_if_read = 1'b0; #1;
        chk("t1_vld2",  b1.o_if_valid, 1);
        chk("t1_dat2",  b1.o_if_rddata, 16'hA5A1);
        chk("t1_lsvld", b1.o_ls_valid, 0);
        chk("t1_idle_w", {b1.o_if_waitreq, b1.o_ls_waitreq}, 0);
        chk("t1_idle_m", {b1.o_mem_read, b1.o_mem_write, b1.o_mem_addr}, 0);
        tick(); #1;
        chk("t1_vld_off", b1.o_if_valid, 0);

        // Simultaneous fetch and load: load first
        b1.i_if_read = 1'b1; b1.i_if_addr = 16'h0010;
        b1.i_ls_read = 1'b1; b1.i_ls_addr = 16'h0100; #1;
        chk("t2_ifw",  b1.o_if_waitreq, 1);
        chk("t2_lsw",  b1.o_ls_waitreq, 0);
        chk("t2_addr", b1.o_mem_addr, 16'h0100);
        tick();
        b1.i_ls_read = 1'b0; #1;
        chk("t2_ifw2",  b1.o_if_waitreq, 0);
        chk("t2_addr2", b1.o_mem_addr, 16'h0010);
        chk("t2_lsvld", b1.o_ls_valid, 1);
        chk("t2_lsdat", b1.o_ls_rddata, 16'hA4A5);
        chk("t2_ifvld0", b1.o_if_valid, 0);
        tick();
        b1.i_if_read = 1'b0; #1;
        chk("t2_ifvld", b1.o_if_valid, 1);
        chk("t2_ifdat", b1.o_if_rddata, 16'hA5B5);
        chk("t2_lsvld0", b1.o_ls_valid, 0);
        tick();

        // Starvation: fetch held against a load stream
        b1.i_if_read = 1'b1; b1.i_if_addr = 16'h0020;
        b1.i_ls_read = 1'b1; b1.i_ls_addr = 16'h0030; #1;
        chk("t3_c1_ifw", b1.o_if_waitreq, 1);
        chk("t3_c1_lsw", b1.o_ls_waitreq, 0);
        tick();
        b1.i_ls_addr = 16'h0031; #1;
        chk("t3_c2_ifw", b1.o_if_waitreq, 1);
        tick();
        b1.i_ls_addr = 16'h0032; #1;
        chk("t3_c3_ifw", b1.o_if_waitreq, 1);
        chk("t3_c3_lsw", b1.o_ls_waitreq, 0);
        chk("t3_starve2", dut1.r_starve, 2);
        tick();
        b1.i_ls_addr = 16'h0033; #1;
        chk("t3_c4_ifw",  b1.o_if_waitreq, 0);
        chk("t3_c4_lsw",  b1.o_ls_waitreq, 1);
        chk("t3_c4_addr", b1.o_mem_addr, 16'h0020);
        chk("t3_c4_lsv",  b1.o_ls_valid, 1);
        chk("t3_c4_lsd",  b1.o_ls_rddata, 16'hA597);
        tick();
        b1.i_if_addr = 16'h0022; #1;
        chk("t3_c5_lsw", b1.o_ls_waitreq, 0);
        chk("t3_c5_ifw", b1.o_if_waitreq, 1);
        chk("t3_c5_ifv", b1.o_if_valid, 1);
        chk("t3_c5_ifd", b1.o_if_rddata, 16'hA585);
        chk("t3_c5_lsv", b1.o_ls_valid, 0);
        tick();
        b1.i_ls_read = 1'b0; #1;
        chk("t3_c6_ifw", b1.o_if_waitreq, 0);
        chk("t3_c6_lsv", b1.o_ls_valid, 1);
        chk("t3_c6_lsd", b1.o_ls_rddata, 16'hA596);
        tick();
        b1.i_if_read = 1'b0; #1;
        chk("t3_c7_ifv", b1.o_if_valid, 1);
        chk("t3_c7_ifd", b1.o_if_rddata, 16'hA587);
        tick();

        // Store (read+write set acts as write), then load back
        b1.i_ls_write = 1'b1; b1.i_ls_read = 1'b1;
        b1.i_ls_addr = 16'h0040; b1.i_ls_wrdata = 16'hBEEF; #1;
        chk("t4_mwr",   b1.o_mem_write, 1);
        chk("t4_mrd",   b1.o_mem_read, 0);
        chk("t4_wdat",  b1.o_mem_wrdata, 16'hBEEF);
        chk("t4_addr",  b1.o_mem_addr, 16'h0040);
        tick();
        b1.i_ls_write = 1'b0; #1;
        chk("t4_ldrd",  b1.o_mem_read, 1);
        chk("t4_nostb", b1.o_ls_valid, 0);
        tick();
        b1.i_ls_read = 1'b0; #1;
        chk("t4_lsv",   b1.o_ls_valid, 1);
        chk("t4_lsd",   b1.o_ls_rddata, 16'hBEEF);
        tick(); #1;
        chk("t4_lsv0",  b1.o_ls_valid, 0);

        // Memory stall during fetch; starve count must hold at 1
        b1.i_if_read = 1'b1; b1.i_if_addr = 16'h0004;
        b1.i_ls_read = 1'b1; b1.i_ls_addr = 16'h0002; #1;
        chk("t5_pre_ifw", b1.o_if_waitreq, 1);
        tick();
        b1.i_ls_read = 1'b0; b1.i_mem_waitreq = 1'b1; #1;
        chk("t5_s1_ifw", b1.o_if_waitreq, 1);
        chk("t5_s1_mrd", b1.o_mem_read, 1);
        chk("t5_s1_lsv", b1.o_ls_valid, 1);
        chk("t5_s1_lsd", b1.o_ls_rddata, 16'hA5A7);
        tick(); #1;
        chk("t5_s2_ifw", b1.o_if_waitreq, 1);
        chk("t5_s2_ifv", b1.o_if_valid, 0);
        chk("t5_s2_stv", dut1.r_starve, 1);
        tick();
        b1.i_mem_waitreq = 1'b0; #1;
        chk("t5_acc_ifw", b1.o_if_waitreq, 0);
        chk("t5_acc_ifv", b1.o_if_valid, 0);
        chk("t5_acc_stv", dut1.r_starve, 1);
        tick();
        b1.i_if_read = 1'b0; #1;
        chk("t5_ifv", b1.o_if_valid, 1);
        chk("t5_ifd", b1.o_if_rddata, 16'hA5A1);
        chk("t5_stv0", dut1.r_starve, 0);
        tick();

        // RDLAT=3: reset with two reads in flight
        b2.i_if_read = 1'b1; b2.i_if_addr = 16'h0010; #1;
        chk("t6_c1_ifw", b2.o_if_waitreq, 0);
        tick();
        b2.i_if_addr = 16'h0012; #1;
        chk("t6_c2_ifw", b2.o_if_waitreq, 0);
        chk("t6_c2_ifv", b2.o_if_valid, 0);
        tick();
        rst2 = 1'b1; b2.i_if_addr = 16'h0050; #1;
        chk("t6_rst_ifw", b2.o_if_waitreq, 1);
        chk("t6_rst_lsw", b2.o_ls_waitreq, 1);
        chk("t6_rst_mrd", b2.o_mem_read, 0);
        chk("t6_rst_ifv", b2.o_if_valid, 0);
        tick();
        rst2 = 1'b0; #1;
        chk("t6_r1_ifw", b2.o_if_waitreq, 0);
        chk("t6_r1_ifv", b2.o_if_valid, 0);
        tick();
        b2.i_if_read = 1'b0; #1;
        chk("t6_r2_ifv", b2.o_if_valid, 0);
        tick(); #1;
        chk("t6_r3_ifv", b2.o_if_valid, 0);
        tick(); #1;
        chk("t6_r4_ifv", b2.o_if_valid, 1);
        chk("t6_r4_ifd", b2.o_if_rddata, 16'hA5F5);
        chk("t6_r4_lsv", b2.o_ls_valid, 0);
        tick(); #1;
        chk("t6_r5_ifv", b2.o_if_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
